// File: rtl/sprite_ram_loader.sv
// sprite_ram_loader: packs an R,G,B byte stream into 24-bit pixels written sequentially to a sprite RAM.
// Optional trailing checksum byte verification when SPRITE_LOADER_CHECKSUM_EN is defined.
module sprite_ram_loader #(
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] write_address,
  output logic [23:0]       data_In,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int CNT_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);
  typedef enum logic [2:0] {
    IDLE, GET_R, GET_G, GET_B, WRITE, FINISH
`ifdef SPRITE_LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0] data_q, data_d;
  logic error_q, error_d, byte_ready_q, byte_ready_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic xfer;
  assign xfer = byte_valid && byte_ready_q;
`ifdef SPRITE_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  assign sum_d = (state_q == IDLE && start) ? 8'd0 :
                 (xfer && state_q != CHECK) ? sum_q + byte_in : sum_q;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) sum_q <= '0;
    else sum_q <= sum_d;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    error_d = error_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = GET_R;
        cnt_d   = '0;
        addr_d  = BASE;
        error_d = 1'b0;
      end
      GET_R: if (xfer) begin
        data_d[23:16] = byte_in;
        state_d = GET_G;
      end
      GET_G: if (xfer) begin
        data_d[15:8] = byte_in;
        state_d = GET_B;
      end
      GET_B: if (xfer) begin
        data_d[7:0] = byte_in;
        state_d = WRITE;
      end
      WRITE: if (cnt_q == LAST) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
        state_d = CHECK;
`else
        state_d = FINISH;
`endif
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        addr_d  = addr_q + ADDR_W'(1);
        state_d = GET_R;
      end
`ifdef SPRITE_LOADER_CHECKSUM_EN
      CHECK: if (xfer) begin
        error_d = error_q | (byte_in != sum_q);
        state_d = FINISH;
      end
`endif
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start && state_q != IDLE) error_d = 1'b1;
    // Outputs are registered from the next state so they line up with it.
`ifdef SPRITE_LOADER_CHECKSUM_EN
    byte_ready_d = state_d inside {GET_R, GET_G, GET_B, CHECK};
`else
    byte_ready_d = state_d inside {GET_R, GET_G, GET_B};
`endif
    we_d   = state_d == WRITE;
    busy_d = state_d != IDLE;
    done_d = state_d == FINISH;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= BASE;
      data_q       <= '0;
      error_q      <= 1'b0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      error_q      <= error_d;
      byte_ready_q <= byte_ready_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  assign byte_ready    = byte_ready_q;
  assign we            = we_q;
  assign write_address = addr_q;
  assign data_In       = data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
endmodule

// File: tb/tb_sprite_ram_loader.sv
// tb_sprite_ram_loader: directed and randomized loads checked against a pixel-list reference model.
module tb_sprite_ram_loader;
  localparam int DEPTH = 4;
  localparam int BASE  = 16;
`ifdef SPRITE_LOADER_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  logic Clk = 0, Reset_n = 0, start = 0, byte_valid = 0;
  logic [7:0] byte_in = 0;
  logic byte_ready, we, busy, done, error;
  logic [7:0] write_address;
  logic [23:0] data_In;
  int checks = 0, errors = 0;
  logic [31:0] wq[$];
  sprite_ram_loader #(.DEPTH(DEPTH), .ADDR_W(8), .BASE_ADDR(BASE)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .byte_valid(byte_valid), .byte_in(byte_in),
    .byte_ready(byte_ready), .we(we), .write_address(write_address), .data_In(data_In),
    .busy(busy), .done(done), .error(error)
  );
  always #5 Clk = ~Clk;
  always @(negedge Clk) if (Reset_n && we) wq.push_back({write_address, data_In});
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic void payload(output logic [7:0] b[$], input bit rnd, input bit bad);
    logic [7:0] s = 0;
    b = {};
    for (int i = 0; i < 3 * DEPTH; i++) begin
      b.push_back(rnd ? 8'($urandom) : 8'(i + 1));
      s += b[i];
    end
    if (CHK == 1) b.push_back(s + 8'(bad));
  endfunction
  task automatic check_writes(input string tag, input logic [7:0] b[$]);
    chk({tag, "_count"}, wq.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < wq.size(); i++)
      chk($sformatf("%s_px%0d", tag, i), wq[i], {8'(BASE + i), b[3*i], b[3*i+1], b[3*i+2]});
    wq.delete();
  endtask
  // mode: 0 full rate, 1 toggling valid, 2 random valid
  task automatic run_load(input logic [7:0] b[$], input int mode, input int start_at,
                          input int abort_at, output int lat, output int dones);
    int idx = 0, cyc = 0;
    bit tog = 0, fired = 0, v;
    lat = -1;
    dones = 0;
    @(negedge Clk);
    start = 1;
    while (cyc < 2000) begin
      @(negedge Clk);
      cyc++;
      start = 0;
      if (start_at >= 0 && idx == start_at && !fired) begin
        start = 1;
        fired = 1;
      end
      if (done) begin
        dones++;
        if (lat < 0) lat = cyc;
      end
      if (abort_at >= 0 && idx == abort_at) begin
        Reset_n = 0;
        byte_valid = 0;
        start = 0;
        #1;
        return;
      end
      v = idx < b.size() && (mode == 0 ? 1'b1 : mode == 1 ? tog : 1'($urandom));
      tog = ~tog;
      byte_valid = v;
      byte_in = idx < b.size() ? b[idx] : 8'hEE;
      if (v && byte_ready) idx++;
      if (lat >= 0 && cyc >= lat + 3) break;
    end
    start = 0;
    byte_valid = 0;
    chk("no_timeout", lat >= 0, 1);
  endtask
  initial begin
    logic [7:0] b[$];
    int lat, dones;
    repeat (3) @(negedge Clk);
    chk("rst_ready", byte_ready, 0);
    chk("rst_we", we, 0);
    chk("rst_addr", write_address, BASE);
    chk("rst_data", data_In, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    Reset_n = 1;
    payload(b, 0, 0);
    run_load(b, 0, -1, -1, lat, dones);
    check_writes("full", b);
    chk("full_latency", lat, 4 * DEPTH + 1 + CHK);
    chk("full_dones", dones, 1);
    chk("full_error", error, 0);
    chk("full_busy_after", busy, 0);
    chk("addr_hold", write_address, BASE + DEPTH - 1);
    chk("data_hold", data_In, 24'h0A0B0C);
    run_load(b, 1, -1, -1, lat, dones);
    check_writes("toggle", b);
    chk("toggle_dones", dones, 1);
    chk("toggle_error", error, 0);
    for (int r = 0; r < 3; r++) begin
      payload(b, 1, 0);
      run_load(b, 2, -1, -1, lat, dones);
      check_writes($sformatf("rand%0d", r), b);
      chk($sformatf("rand%0d_dones", r), dones, 1);
      chk($sformatf("rand%0d_error", r), error, 0);
    end
    payload(b, 1, 0);
    run_load(b, 0, 4, -1, lat, dones);
    check_writes("sbusy", b);
    chk("sbusy_error", error, 1);
    chk("sbusy_dones", dones, 1);
    payload(b, 0, 0);
    run_load(b, 0, -1, -1, lat, dones);
    check_writes("after_sbusy", b);
    chk("error_cleared", error, 0);
    run_load(b, 1, -1, 4, lat, dones);
    chk("abort_we", we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", write_address, BASE);
    chk("abort_ready", byte_ready, 0);
    wq.delete();
    @(negedge Clk);
    Reset_n = 1;
    payload(b, 1, 0);
    run_load(b, 0, -1, -1, lat, dones);
    check_writes("post_abort", b);
    chk("post_abort_dones", dones, 1);
`ifdef SPRITE_LOADER_CHECKSUM_EN
    payload(b, 1, 1);
    run_load(b, 2, -1, -1, lat, dones);
    check_writes("badsum", b);
    chk("badsum_error", error, 1);
    chk("badsum_dones", dones, 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
